lift_seq: RTL and testbench

LIFT_SEQ -- requirements
Module: lift_seq

---
 rtl/lift_pkg.sv | 19 +
 rtl/lift_alu.sv | 40 ++++
 rtl/lift_seq.sv | 177 +++++++++++++++++
 tb/tb_lift_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared defaults and FSM encoding for the 5/3 lifting row sequencer.
package lift_pkg;

   localparam int unsigned W_DEF     = 9;
   localparam int unsigned AW_DEF    = 7;
   localparam int unsigned NPAIR_DEF = 128;

   typedef enum logic [2:0] {
      IDLE,
      PA,
      PB,
      PC,
      UA,
      UB,
      UC,
      DONE
   } lift_state_e;

endpackage

// File: rtl/lift_alu.sv
// Combinational 5/3 predict/update arithmetic: computes one new odd (predict) or even (update)
// sample from two neighbours and the centre sample.
module lift_alu
   import lift_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         upd,
   input  logic         fwd,
   input  logic [W-1:0] nb0,
   input  logic [W-1:0] nb1,
   input  logic [W-1:0] ctr,
   output logic [W-1:0] res
);

   localparam int unsigned SW = W + 2;

   logic signed [SW-1:0] nb0_x;
   logic signed [SW-1:0] nb1_x;
   logic signed [SW-1:0] ctr_x;
   logic signed [SW-1:0] rnd;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] step;
   logic signed [SW-1:0] full;
   logic                 add;

   always_comb begin
      nb0_x = {{2{nb0[W-1]}}, nb0};
      nb1_x = {{2{nb1[W-1]}}, nb1};
      ctr_x = {{2{ctr[W-1]}}, ctr};
      rnd   = upd ? SW'(2) : '0;
      sum   = nb0_x + nb1_x + rnd;
      step  = upd ? (sum >>> 2) : (sum >>> 1);
      // Forward predict subtracts, forward update adds; inverse swaps both.
      add   = upd ? fwd : !fwd;
      full  = add ? (ctr_x + step) : (ctr_x - step);
      res   = full[W-1:0];
   end

endmodule

// File: rtl/lift_seq.sv
// Row sequencer for an in-place 5/3 lifting transform over external even/odd sample banks
// with one-cycle synchronous read latency.
module lift_seq
   import lift_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned NPAIR = NPAIR_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          fwd_inv,
   output logic [AW-1:0] pix_addr_even,
   output logic [AW-1:0] pix_addr_odd,
   output logic          pix_we_even,
   output logic          pix_we_odd,
   output logic [W-1:0]  pix_din_even,
   output logic [W-1:0]  pix_din_odd,
   input  logic [W-1:0]  pix_dout_even,
   input  logic [W-1:0]  pix_dout_odd,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] Last = AW'(NPAIR - 1);

   lift_state_e   state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          fwd_q, fwd_d;
   logic          second_q, second_d;
   logic [W-1:0]  cap_a_q, cap_a_d;
   logic [W-1:0]  cap_b_q, cap_b_d;
   logic [W-1:0]  din_even_q;
   logic [W-1:0]  din_odd_q;

   logic          alu_upd;
   logic [W-1:0]  alu_nb1;
   logic [W-1:0]  alu_res;

   lift_alu #(
      .W (W)
   ) u_alu (
      .upd (alu_upd),
      .fwd (fwd_q),
      .nb0 (cap_a_q),
      .nb1 (alu_nb1),
      .ctr (cap_b_q),
      .res (alu_res)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      fwd_d         = fwd_q;
      second_d      = second_q;
      cap_a_d       = cap_a_q;
      cap_b_d       = cap_b_q;
      pix_addr_even = '0;
      pix_addr_odd  = '0;
      pix_we_even   = 1'b0;
      pix_we_odd    = 1'b0;
      alu_upd       = 1'b0;
      alu_nb1       = pix_dout_even;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               fwd_d    = fwd_inv;
               idx_d    = '0;
               second_d = 1'b0;
               state_d  = fwd_inv ? PA : UA;
            end
         end
         PA: begin
            pix_addr_even = idx_q;
            pix_addr_odd  = idx_q;
            state_d       = PB;
         end
         PB: begin
            cap_a_d       = pix_dout_even;
            cap_b_d       = pix_dout_odd;
            // Right edge mirrors onto the last even sample.
            pix_addr_even = (idx_q == Last) ? idx_q : idx_q + AW'(1);
            pix_addr_odd  = idx_q;
            state_d       = PC;
         end
         PC: begin
            pix_addr_even = idx_q;
            pix_addr_odd  = idx_q;
            pix_we_odd    = 1'b1;
            alu_nb1       = pix_dout_even;
            if (idx_q == Last) begin
               idx_d = '0;
               if (second_q) begin
                  state_d = DONE;
               end else begin
                  second_d = 1'b1;
                  state_d  = UA;
               end
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = PA;
            end
         end
         UA: begin
            // Left edge mirrors onto the first odd sample.
            pix_addr_odd  = (idx_q == '0) ? '0 : idx_q - AW'(1);
            pix_addr_even = idx_q;
            state_d       = UB;
         end
         UB: begin
            cap_a_d       = pix_dout_odd;
            cap_b_d       = pix_dout_even;
            pix_addr_even = idx_q;
            pix_addr_odd  = idx_q;
            state_d       = UC;
         end
         UC: begin
            pix_addr_even = idx_q;
            pix_addr_odd  = idx_q;
            pix_we_even   = 1'b1;
            alu_upd       = 1'b1;
            alu_nb1       = pix_dout_odd;
            if (idx_q == Last) begin
               idx_d = '0;
               if (second_q) begin
                  state_d = DONE;
               end else begin
                  second_d = 1'b1;
                  state_d  = PA;
               end
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = UA;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Write data is live in the C state and held afterwards.
   always_comb begin
      pix_din_odd  = (state_q == PC) ? alu_res : din_odd_q;
      pix_din_even = (state_q == UC) ? alu_res : din_even_q;
      busy         = (state_q != IDLE);
      done         = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         fwd_q      <= 1'b1;
         second_q   <= 1'b0;
         cap_a_q    <= '0;
         cap_b_q    <= '0;
         din_even_q <= '0;
         din_odd_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         fwd_q      <= fwd_d;
         second_q   <= second_d;
         cap_a_q    <= cap_a_d;
         cap_b_q    <= cap_b_d;
         din_even_q <= pix_din_even;
         din_odd_q  <= pix_din_odd;
      end
   end

endmodule

// File: tb/tb_lift_seq.sv
// Scoreboard bench for lift_seq: behavioural banks, an array-level lifting model that queues
// expected writes, and a monitor that pops and compares each observed write.
module tb_lift_seq;
   import lift_pkg::*;

   localparam int unsigned W   = W_DEF;
   localparam int unsigned AW  = AW_DEF;
   localparam int unsigned N   = NPAIR_DEF;
   localparam int          Lat = 6 * N + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          fwd_inv = 1'b1;
   logic [AW-1:0] addr_e, addr_o;
   logic          we_e, we_o;
   logic [W-1:0]  din_e, din_o;
   logic [W-1:0]  dout_e, dout_o;
   logic          busy, done;

   always #5 clk = ~clk;

   lift_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .fwd_inv       (fwd_inv),
      .pix_addr_even (addr_e),
      .pix_addr_odd  (addr_o),
      .pix_we_even   (we_e),
      .pix_we_odd    (we_o),
      .pix_din_even  (din_e),
      .pix_din_odd   (din_o),
      .pix_dout_even (dout_e),
      .pix_dout_odd  (dout_o),
      .busy          (busy),
      .done          (done)
   );

   logic [W-1:0]  mem_e [N];
   logic [W-1:0]  mem_o [N];
   logic          ld = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [W-1:0]  ld_e = '0;
   logic [W-1:0]  ld_o = '0;

   always @(posedge clk) begin
      if (ld) begin
         mem_e[ld_addr] <= ld_e;
         mem_o[ld_addr] <= ld_o;
      end else begin
         if (we_e) mem_e[addr_e] <= din_e;
         if (we_o) mem_o[addr_o] <= din_o;
      end
      dout_e <= mem_e[addr_e];
      dout_o <= mem_o[addr_o];
   end

   typedef struct {
      bit even;
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  me [N];
   int  mo [N];
   int  orig_e [N];
   int  orig_o [N];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int wrap(input int v);
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return int'(t);
   endfunction

   function automatic int sv(input logic [W-1:0] x);
      return int'($signed(x));
   endfunction

   // Array-level reference of one predict pass; queues every odd-bank write in order.
   task automatic model_p(input bit f);
      for (int i = 0; i < int'(N); i++) begin
         int e1, d;
         wr_t w;
         e1 = (i == int'(N) - 1) ? me[i] : me[i + 1];
         d = (me[i] + e1) >>> 1;
         mo[i] = wrap(f ? mo[i] - d : mo[i] + d);
         w.even = 1'b0;
         w.addr = i;
         w.data = mo[i];
         exp_q.push_back(w);
      end
   endtask

   task automatic model_u(input bit f);
      for (int i = 0; i < int'(N); i++) begin
         int o0, d;
         wr_t w;
         o0 = (i == 0) ? mo[0] : mo[i - 1];
         d = (o0 + mo[i] + 2) >>> 2;
         me[i] = wrap(f ? me[i] + d : me[i] - d);
         w.even = 1'b1;
         w.addr = i;
         w.data = me[i];
         exp_q.push_back(w);
      end
   endtask

   bit have_prev = 1'b0;
   bit prev_even = 1'b0;
   int prev_addr = 0;

   always @(negedge clk) begin : monitor
      bit  ev;
      int  ad;
      int  dt;
      wr_t w;
      if (!busy) have_prev = 1'b0;
      if (we_e || we_o) begin
         check("one_we", int'(we_e && we_o), 0);
         ev = we_e;
         ad = ev ? int'(addr_e) : int'(addr_o);
         dt = ev ? sv(din_e) : sv(din_o);
         if (have_prev && prev_even == ev) check("addr_incr", int'(ad > prev_addr), 1);
         have_prev = 1'b1;
         prev_even = ev;
         prev_addr = ad;
         check("wr_pending", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("wr_bank", int'(ev), int'(w.even));
            check("wr_addr", ad, w.addr);
            check("wr_data", dt, w.data);
         end
      end
   end

   task automatic load_banks();
      for (int a = 0; a < int'(N); a++) begin
         @(negedge clk);
         ld      = 1'b1;
         ld_addr = AW'(a);
         ld_e    = W'(me[a]);
         ld_o    = W'(mo[a]);
      end
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_we_e"}, int'(we_e), 0);
      check({tag, "_we_o"}, int'(we_o), 0);
      check({tag, "_addr_e"}, int'(addr_e), 0);
      check({tag, "_addr_o"}, int'(addr_o), 0);
      check({tag, "_din_e"}, int'(din_e), 0);
      check({tag, "_din_o"}, int'(din_o), 0);
   endtask

   // Runs one row; cycle k is the k-th cycle after the edge that samples start.
   task automatic run_row(input bit f, input int pulse_at, input int rst_at);
      if (f) begin
         model_p(f);
         model_u(f);
      end else begin
         model_u(f);
         model_p(f);
      end
      @(negedge clk);
      start   = 1'b1;
      fwd_inv = f;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= Lat + 1; k++) begin
         @(negedge clk);
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("mid_rst");
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (60) @(negedge clk);
            return;
         end
         check("busy", int'(busy), int'(k <= Lat));
         check("done", int'(done), int'(k == Lat));
         if (k == pulse_at) begin
            start   = 1'b1;
            fwd_inv = ~f;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_banks_vs(input string tag, input bit use_orig);
      for (int i = 0; i < int'(N); i++) begin
         check({tag, "_even"}, sv(mem_e[i]), use_orig ? orig_e[i] : me[i]);
         check({tag, "_odd"}, sv(mem_o[i]), use_orig ? orig_o[i] : mo[i]);
      end
   endtask

   function automatic int rand_pix();
      int r;
      r = int'($urandom_range(0, 7));
      case (r)
         0:       return -256;
         1:       return 255;
         2:       return -256 + int'($urandom_range(0, 3));
         3:       return 255 - int'($urandom_range(0, 3));
         default: return int'($urandom_range(0, 511)) - 256;
      endcase
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Constant row: details vanish, approximations keep the constant.
      for (int i = 0; i < int'(N); i++) begin
         me[i] = 100;
         mo[i] = 100;
      end
      load_banks();
      run_row(1'b1, 0, 0);
      for (int i = 0; i < int'(N); i++) begin
         check("const_even", sv(mem_e[i]), 100);
         check("const_odd", sv(mem_o[i]), 0);
      end

      // Ramp with a stray start at cycle 300, then inverse with a start during DONE.
      for (int i = 0; i < int'(N); i++) begin
         me[i] = 2 * i;
         mo[i] = 2 * i + 1;
      end
      load_banks();
      run_row(1'b1, 300, 0);
      for (int i = 0; i < int'(N); i++) begin
         check("ramp_even", sv(mem_e[i]), 2 * i);
         check("ramp_odd", sv(mem_o[i]), (i == int'(N) - 1) ? 1 : 0);
      end
      run_row(1'b0, Lat, 0);
      for (int i = 0; i < int'(N); i++) begin
         check("ramp_inv_even", sv(mem_e[i]), 2 * i);
         check("ramp_inv_odd", sv(mem_o[i]), 2 * i + 1);
      end

      // Reset at cycle 200 aborts the row; a fresh row afterwards completes normally.
      for (int i = 0; i < int'(N); i++) begin
         me[i] = rand_pix();
         mo[i] = rand_pix();
      end
      load_banks();
      run_row(1'b1, 0, 200);
      for (int i = 0; i < int'(N); i++) begin
         me[i] = rand_pix();
         mo[i] = rand_pix();
      end
      load_banks();
      run_row(1'b1, 0, 0);
      check_banks_vs("post_rst", 1'b0);

      // Random forward/inverse round trips must be bit-exact.
      for (int s = 0; s < 30; s++) begin
         for (int i = 0; i < int'(N); i++) begin
            me[i]     = rand_pix();
            mo[i]     = rand_pix();
            orig_e[i] = me[i];
            orig_o[i] = mo[i];
         end
         load_banks();
         run_row(1'b1, 0, 0);
         run_row(1'b0, 0, 0);
         check_banks_vs("roundtrip", 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
